// File: rtl/seq_detect_pkg.sv
// Shared types and sizing helpers for the sequence-detector controller.
package seq_detect_pkg;

    localparam int unsigned MAX_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } ctrl_state_t;

    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial match core: history shift register, fill counter, masked pattern compare
// and optional history clear after a match.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match_c
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   hist_len_q, hist_len_d;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_inc;

    // Candidate history and fill level if this cycle's bit is accepted.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
        len_inc    = (hist_len_q >= len) ? len : hist_len_q + LEN_W'(1);
        mask       = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match_c = shift_en && (len_inc == len) && (((hist_shift ^ pattern) & mask) == '0);
    end

    always_comb begin
        hist_d     = hist_q;
        hist_len_d = hist_len_q;
        if (clear) begin
            hist_d     = '0;
            hist_len_d = '0;
        end else if (shift_en) begin
            hist_d     = hist_shift;
            hist_len_d = (match_c && !overlap) ? '0 : len_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q     <= '0;
            hist_len_q <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_len_q <= hist_len_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: config handshake, IDLE/ARMED/RUN FSM, match counter.
// Define SEQ_DETECT_CTRL_ASSERT_EN to compile in the embedded assertions.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               detect,
    output logic               busy,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         current
);

    ctrl_state_t        state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               detect_q, detect_d;
    logic               cfg_err_q, cfg_err_d;

    logic hs, legal, run_start, shift_en, match_c;

    assign hs        = cfg_valid && cfg_ready;
    assign legal     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign run_start = (state_q == ARMED) && start && !hs;
    assign shift_en  = (state_q == RUN) && in_valid && !stop;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A config handshake in ARMED takes priority over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs && legal) state_d = ARMED;
            ARMED:   if (!hs && start) state_d = RUN;
            RUN:     if (stop) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE, ARMED: cfg_ready = 1'b1;
            RUN:         busy      = 1'b1;
            default:     ;
        endcase
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (run_start),
        .shift_en (shift_en),
        .in_bit   (in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match_c  (match_c)
    );

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cnt_d     = cnt_q;
        detect_d  = match_c;
        cfg_err_d = hs && !legal;
        if (hs && legal) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
        end
        if (run_start) begin
            cnt_d = '0;
        end else if (match_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cnt_q     <= '0;
            detect_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cnt_q     <= cnt_d;
            detect_q  <= detect_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign current     = 2'(state_q);
    assign detect      = detect_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = cnt_q;

`ifdef SEQ_DETECT_CTRL_ASSERT_EN
    a_no_x: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({current, detect, match_count}));
    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        current != 2'd3);
    a_detect_src: assert property (@(posedge clk) disable iff (rst)
        detect |-> $past(state_q == RUN && in_valid));
    a_ready_busy: assert property (@(posedge clk) disable iff (rst)
        !(cfg_ready && busy));
`else
    // Assertions compiled out; behaviour is unchanged.
`endif

endmodule
